// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   REG_W   : register index width
//   CNT_W   : performance counter width
//   fwd_sel_e: EX operand source select (regfile / WB / MEM)
package hazard_control_unit_pkg;

   localparam int REG_W = 5;
   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   // One in-flight stage of the destination scoreboard.
   typedef struct packed {
      logic [REG_W-1:0] dst;
      logic             wr;
      logic             ld;
   } sb_slot_t;

endpackage

// File: rtl/hazard_control_unit_dst_match.sv
// Compares one scoreboard slot against a source register index.
//   slot_wr  : slot writes the register file
//   slot_dst : slot destination register
//   src      : source index being checked
//   hit      : slot is a real writer (wr=1, dst!=0) and dst==src
module hazard_control_unit_dst_match
   import hazard_control_unit_pkg::*;
(
   input  logic             slot_wr,
   input  logic [REG_W-1:0] slot_dst,
   input  logic [REG_W-1:0] src,
   output logic             hit
);

   // Register 0 is hard-wired, so a write to it never produces a hazard.
   assign hit = slot_wr && (slot_dst != '0) && (slot_dst == src);

endmodule

// File: rtl/hazard_control_unit.sv
// Central hazard controller for the 5-stage MIPS pipeline.
// Tracks destination registers in EX/MEM/WB and drives stalls, flushes,
// EX forwarding selects, ID branch-compare forwarding and the WB->ID bypass.
//   inputs : clk, rst (async, active-high), ID-stage instruction fields,
//            branch_taken
//   outputs: pc_write, ifid_write, idex_bubble, ifid_flush, fwd_a/b,
//            br_fwd_a/b, id_wb_byp_rs/rt, stall_cnt, flush_cnt
module hazard_control_unit
   import hazard_control_unit_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic [REG_W-1:0] id_dst,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             id_is_branch,
   input  logic             id_is_jump,
   input  logic             branch_taken,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             idex_bubble,
   output logic             ifid_flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             br_fwd_a,
   output logic             br_fwd_b,
   output logic             id_wb_byp_rs,
   output logic             id_wb_byp_rt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   sb_slot_t         ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
   logic [REG_W-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   logic ex_id_rs, ex_id_rt, mem_id_rs, mem_id_rt, wb_id_rs, wb_id_rt;
   logic mem_ex_rs, mem_ex_rt, wb_ex_rs, wb_ex_rt;
   logic ex_hit, mem_hit, stall, flush;

   hazard_control_unit_dst_match u_ex_id_rs  (.slot_wr(ex_q.wr),  .slot_dst(ex_q.dst),  .src(id_rs),   .hit(ex_id_rs));
   hazard_control_unit_dst_match u_ex_id_rt  (.slot_wr(ex_q.wr),  .slot_dst(ex_q.dst),  .src(id_rt),   .hit(ex_id_rt));
   hazard_control_unit_dst_match u_mem_id_rs (.slot_wr(mem_q.wr), .slot_dst(mem_q.dst), .src(id_rs),   .hit(mem_id_rs));
   hazard_control_unit_dst_match u_mem_id_rt (.slot_wr(mem_q.wr), .slot_dst(mem_q.dst), .src(id_rt),   .hit(mem_id_rt));
   hazard_control_unit_dst_match u_wb_id_rs  (.slot_wr(wb_q.wr),  .slot_dst(wb_q.dst),  .src(id_rs),   .hit(wb_id_rs));
   hazard_control_unit_dst_match u_wb_id_rt  (.slot_wr(wb_q.wr),  .slot_dst(wb_q.dst),  .src(id_rt),   .hit(wb_id_rt));
   hazard_control_unit_dst_match u_mem_ex_rs (.slot_wr(mem_q.wr), .slot_dst(mem_q.dst), .src(ex_rs_q), .hit(mem_ex_rs));
   hazard_control_unit_dst_match u_mem_ex_rt (.slot_wr(mem_q.wr), .slot_dst(mem_q.dst), .src(ex_rt_q), .hit(mem_ex_rt));
   hazard_control_unit_dst_match u_wb_ex_rs  (.slot_wr(wb_q.wr),  .slot_dst(wb_q.dst),  .src(ex_rs_q), .hit(wb_ex_rs));
   hazard_control_unit_dst_match u_wb_ex_rt  (.slot_wr(wb_q.wr),  .slot_dst(wb_q.dst),  .src(ex_rt_q), .hit(wb_ex_rt));

   always_comb begin
      ex_hit  = (id_uses_rs && ex_id_rs)  || (id_uses_rt && ex_id_rt);
      mem_hit = (id_uses_rs && mem_id_rs) || (id_uses_rt && mem_id_rt);

      // Branches compare in ID, so they also wait on ALU results still in EX
      // and on load data that only exists after MEM.
      stall = id_valid && ((ex_q.ld && ex_hit) ||
                           (id_is_branch && ex_hit) ||
                           (id_is_branch && mem_q.ld && mem_hit));
      flush = !stall && id_valid && ((id_is_branch && branch_taken) || id_is_jump);

      pc_write    = !stall;
      ifid_write  = !stall;
      idex_bubble = stall;
      ifid_flush  = flush;

      fwd_a = mem_ex_rs ? FWD_MEM : (wb_ex_rs ? FWD_WB : FWD_RF);
      fwd_b = mem_ex_rt ? FWD_MEM : (wb_ex_rt ? FWD_WB : FWD_RF);

      // A load in MEM has no ALU result worth forwarding; that case stalls.
      br_fwd_a = mem_id_rs && !mem_q.ld;
      br_fwd_b = mem_id_rt && !mem_q.ld;

      id_wb_byp_rs = wb_id_rs;
      id_wb_byp_rt = wb_id_rt;

      stall_cnt = stall_cnt_q;
      flush_cnt = flush_cnt_q;
   end

   always_comb begin
      wb_d    = mem_q;
      mem_d   = ex_q;
      ex_d    = '0;
      ex_rs_d = '0;
      ex_rt_d = '0;
      if (id_valid && !stall) begin
         ex_d.dst = id_dst;
         ex_d.wr  = id_reg_write;
         ex_d.ld  = id_mem_read;
         ex_rs_d  = id_rs;
         ex_rt_d  = id_rt;
      end

      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      flush_cnt_d = flush_cnt_q;
      if (flush && (flush_cnt_q != '1))
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         ex_rs_q     <= '0;
         ex_rt_q     <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         ex_rs_q     <= ex_rs_d;
         ex_rt_q     <= ex_rt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed pipeline scenarios
// plus randomized instruction streams checked against a behavioural model
// that tracks in-flight instructions as a small array of records.
module tb_hazard_control_unit;

   logic       clk, rst;
   logic       id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
   logic       id_is_branch, id_is_jump, branch_taken;
   logic [4:0] id_rs, id_rt, id_dst;
   logic       pc_write, ifid_write, idex_bubble, ifid_flush;
   logic [1:0] fwd_a, fwd_b;
   logic       br_fwd_a, br_fwd_b, id_wb_byp_rs, id_wb_byp_rt;
   logic [15:0] stall_cnt, flush_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   hazard_control_unit dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_is_branch(id_is_branch), .id_is_jump(id_is_jump),
      .branch_taken(branch_taken), .pc_write(pc_write), .ifid_write(ifid_write),
      .idex_bubble(idex_bubble), .ifid_flush(ifid_flush), .fwd_a(fwd_a),
      .fwd_b(fwd_b), .br_fwd_a(br_fwd_a), .br_fwd_b(br_fwd_b),
      .id_wb_byp_rs(id_wb_byp_rs), .id_wb_byp_rt(id_wb_byp_rt),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   typedef struct {
      int  dst;
      bit  wr;
      bit  ld;
      int  rs;
      int  rt;
   } instr_t;

   instr_t pipe[3];   // [0]=EX, [1]=MEM, [2]=WB
   int m_stall_cnt, m_flush_cnt;

   function automatic bit writes(instr_t s, int r);
      return s.wr && s.dst != 0 && s.dst == r;
   endfunction

   function automatic bit reads_from(instr_t s);
      return (id_uses_rs && writes(s, id_rs)) || (id_uses_rt && writes(s, id_rt));
   endfunction

   function automatic bit m_stall();
      bit load_use, br_alu, br_load;
      load_use = pipe[0].ld && reads_from(pipe[0]);
      br_alu   = id_is_branch && reads_from(pipe[0]);
      br_load  = id_is_branch && pipe[1].ld && reads_from(pipe[1]);
      return id_valid && (load_use || br_alu || br_load);
   endfunction

   function automatic bit m_flush();
      return !m_stall() && id_valid && ((id_is_branch && branch_taken) || id_is_jump);
   endfunction

   function automatic logic [1:0] m_fwd(int r);
      if (writes(pipe[1], r)) return 2'b10;
      if (writes(pipe[2], r)) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0, 0};
      m_stall_cnt = 0;
      m_flush_cnt = 0;
   endtask

   task automatic set_id(input bit v, input int rs, input int rt, input bit urs,
                         input bit urt, input int dst, input bit rw, input bit mr,
                         input bit br, input bit jp, input bit tk);
      id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rs = urs;
      id_uses_rt = urt; id_dst = 5'(dst); id_reg_write = rw; id_mem_read = mr;
      id_is_branch = br; id_is_jump = jp; branch_taken = tk;
   endtask

   task automatic nop();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Advance one clock edge, moving the model in step with the DUT.
   task automatic tick();
      instr_t nx;
      bit st, fl;
      st = m_stall();
      fl = m_flush();
      nx = '{0, 0, 0, 0, 0};
      if (id_valid && !st) nx = '{int'(id_dst), id_reg_write, id_mem_read, int'(id_rs), int'(id_rt)};
      @(posedge clk);
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nx;
      if (st && m_stall_cnt < 65535) m_stall_cnt++;
      if (fl && m_flush_cnt < 65535) m_flush_cnt++;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      nop();
      model_clear();
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      set_id(1, 3, 4, 1, 1, 5, 1, 0, 1, 0, 1);
      #1;
      n_tests++;
      if ({pc_write, ifid_write, idex_bubble, fwd_a, fwd_b, br_fwd_a, br_fwd_b,
           id_wb_byp_rs, id_wb_byp_rt} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
         n_fail++;
         $display("FAIL reset_ctrl: got pc=%b ifid=%b bub=%b fa=%b fb=%b bfa=%b bfb=%b bys=%b byt=%b",
                  pc_write, ifid_write, idex_bubble, fwd_a, fwd_b, br_fwd_a, br_fwd_b,
                  id_wb_byp_rs, id_wb_byp_rt);
      end
      n_tests++;
      if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_cnt: got stall=%0d flush=%0d want 0 0", stall_cnt, flush_cnt);
      end
      nop();
      tick();
   endtask

   task automatic test_load_use();
      do_reset();
      set_id(1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 0);        // lw $8
      #1; tick();
      set_id(1, 8, 8, 1, 1, 9, 1, 0, 0, 0, 0);        // add $9,$8,$8
      #1;
      n_tests++;
      if ({idex_bubble, pc_write, ifid_write} !== 3'b100) begin
         n_fail++;
         $display("FAIL load_use_stall: got bub=%b pc=%b ifid=%b want 1 0 0", idex_bubble, pc_write, ifid_write);
      end
      tick();
      n_tests++;
      if ({idex_bubble, pc_write} !== 2'b01) begin
         n_fail++;
         $display("FAIL load_use_release: got bub=%b pc=%b want 0 1", idex_bubble, pc_write);
      end
      tick();
      nop();
      #1;
      n_tests++;
      if (fwd_a !== 2'b01 || fwd_b !== 2'b01 || stall_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL load_use_fwd: got fa=%b fb=%b stall_cnt=%0d want 01 01 1", fwd_a, fwd_b, stall_cnt);
      end
      tick();
   endtask

   task automatic test_branch_alu();
      do_reset();
      set_id(1, 1, 2, 1, 1, 8, 1, 0, 0, 0, 0);        // add $8
      #1; tick();
      set_id(1, 8, 0, 1, 1, 0, 0, 0, 1, 0, 0);        // beq $8,$0
      #1;
      n_tests++;
      if (idex_bubble !== 1'b1) begin
         n_fail++;
         $display("FAIL br_alu_stall: got bub=%b want 1", idex_bubble);
      end
      tick();
      n_tests++;
      if (idex_bubble !== 1'b0 || br_fwd_a !== 1'b1 || br_fwd_b !== 1'b0) begin
         n_fail++;
         $display("FAIL br_alu_fwd: got bub=%b bfa=%b bfb=%b want 0 1 0", idex_bubble, br_fwd_a, br_fwd_b);
      end
      tick();
      nop();
   endtask

   task automatic test_branch_load();
      do_reset();
      set_id(1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 0);        // lw $8
      #1; tick();
      set_id(1, 8, 0, 1, 1, 0, 0, 0, 1, 0, 1);        // beq $8,$0 (taken ignored while stalled)
      #1;
      n_tests++;
      if (idex_bubble !== 1'b1 || ifid_flush !== 1'b0) begin
         n_fail++;
         $display("FAIL br_load_stall1: got bub=%b flush=%b want 1 0", idex_bubble, ifid_flush);
      end
      tick();
      n_tests++;
      if (idex_bubble !== 1'b1 || br_fwd_a !== 1'b0) begin
         n_fail++;
         $display("FAIL br_load_stall2: got bub=%b bfa=%b want 1 0", idex_bubble, br_fwd_a);
      end
      tick();
      n_tests++;
      if (idex_bubble !== 1'b0 || id_wb_byp_rs !== 1'b1 || stall_cnt !== 16'd2) begin
         n_fail++;
         $display("FAIL br_load_release: got bub=%b byp_rs=%b stall_cnt=%0d want 0 1 2",
                  idex_bubble, id_wb_byp_rs, stall_cnt);
      end
      tick();
      nop();
   endtask

   task automatic test_mem_over_wb();
      do_reset();
      set_id(1, 1, 2, 1, 1, 8, 1, 0, 0, 0, 0); #1; tick();
      set_id(1, 3, 4, 1, 1, 8, 1, 0, 0, 0, 0); #1; tick();
      set_id(1, 8, 8, 1, 1, 10, 1, 0, 0, 0, 0); #1;
      n_tests++;
      if (idex_bubble !== 1'b0) begin
         n_fail++;
         $display("FAIL mem_wb_nostall: got bub=%b want 0", idex_bubble);
      end
      tick();
      nop(); #1;
      n_tests++;
      if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin
         n_fail++;
         $display("FAIL mem_over_wb: got fa=%b fb=%b want 10 10", fwd_a, fwd_b);
      end
      tick();
   endtask

   task automatic test_zero_reg();
      do_reset();
      set_id(1, 1, 2, 1, 1, 0, 1, 1, 0, 0, 0); #1; tick();   // load into $0
      set_id(1, 0, 0, 1, 1, 9, 1, 0, 1, 0, 0); #1;           // branch reading $0
      n_tests++;
      if (idex_bubble !== 1'b0 || pc_write !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_nostall: got bub=%b pc=%b want 0 1", idex_bubble, pc_write);
      end
      tick();
      nop(); #1;
      n_tests++;
      if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || br_fwd_a !== 1'b0 || id_wb_byp_rs !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_fwd: got fa=%b fb=%b bfa=%b byp=%b want 00 00 0 0", fwd_a, fwd_b, br_fwd_a, id_wb_byp_rs);
      end
      tick();
   endtask

   task automatic test_flush();
      do_reset();
      set_id(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 1); #1;           // beq taken
      n_tests++;
      if (ifid_flush !== 1'b1 || pc_write !== 1'b1 || ifid_write !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_beq: got flush=%b pc=%b ifid=%b want 1 1 1", ifid_flush, pc_write, ifid_write);
      end
      tick();
      nop(); #1;
      n_tests++;
      if (ifid_flush !== 1'b0 || flush_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL flush_once: got flush=%b flush_cnt=%0d want 0 1", ifid_flush, flush_cnt);
      end
      set_id(1, 0, 0, 0, 0, 31, 1, 0, 0, 1, 0); #1;          // jal
      n_tests++;
      if (ifid_flush !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_jump: got flush=%b want 1", ifid_flush);
      end
      tick();
      nop(); #1;
      n_tests++;
      if (flush_cnt !== 16'd2 || stall_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL flush_cnt: got flush_cnt=%0d stall_cnt=%0d want 2 0", flush_cnt, stall_cnt);
      end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      set_id(1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 0); #1; tick();
      set_id(1, 8, 2, 1, 1, 9, 1, 0, 0, 0, 0); #1; tick();   // one counted stall
      set_id(1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 0); #1; tick();
      set_id(1, 8, 8, 1, 1, 9, 1, 0, 0, 0, 0); #1;
      n_tests++;
      if (idex_bubble !== 1'b1 || stall_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL pre_reset_stall: got bub=%b stall_cnt=%0d want 1 1", idex_bubble, stall_cnt);
      end
      #1 rst = 1'b1;
      #1;
      n_tests++;
      if ({pc_write, ifid_write, idex_bubble, ifid_flush, fwd_a, fwd_b, stall_cnt, flush_cnt}
          !== {1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 16'd0, 16'd0}) begin
         n_fail++;
         $display("FAIL mid_stall_reset: got pc=%b ifid=%b bub=%b flush=%b fa=%b fb=%b sc=%0d fc=%0d",
                  pc_write, ifid_write, idex_bubble, ifid_flush, fwd_a, fwd_b, stall_cnt, flush_cnt);
      end
      model_clear();
      @(negedge clk);
      rst = 1'b0;
      #1;
      tick();                                                 // dependent add enters EX unstalled
      nop(); #1;
      n_tests++;
      if (stall_cnt !== 16'd0 || fwd_a !== 2'b00) begin
         n_fail++;
         $display("FAIL post_reset_edge: got stall_cnt=%0d fa=%b want 0 00", stall_cnt, fwd_a);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      @(negedge clk);
      force dut.stall_cnt_q = 16'hFFFD;
      #1;
      release dut.stall_cnt_q;
      m_stall_cnt = 16'hFFFD;
      #1;
      for (int k = 0; k < 4; k++) begin
         set_id(1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 0); #1; tick();
         set_id(1, 8, 8, 1, 1, 9, 1, 0, 0, 0, 0); #1; tick();
         tick();
         nop(); #1;
         n_tests++;
         if (stall_cnt !== 16'(m_stall_cnt)) begin
            n_fail++;
            $display("FAIL stall_sat[%0d]: got %h want %h", k, stall_cnt, 16'(m_stall_cnt));
         end
      end
      n_tests++;
      if (stall_cnt !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL stall_sat_final: got %h want ffff", stall_cnt);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         bit st, fl;
         set_id($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 1));
         #1;
         st = m_stall();
         fl = m_flush();
         n_tests++;
         if ({pc_write, ifid_write, idex_bubble, ifid_flush} !== {!st, !st, st, fl}) begin
            n_fail++;
            $display("FAIL rnd_ctrl[%0d]: got pc=%b ifid=%b bub=%b flush=%b want stall=%b flush=%b",
                     i, pc_write, ifid_write, idex_bubble, ifid_flush, st, fl);
         end
         n_tests++;
         if (fwd_a !== m_fwd(pipe[0].rs) || fwd_b !== m_fwd(pipe[0].rt)) begin
            n_fail++;
            $display("FAIL rnd_fwd[%0d]: got fa=%b fb=%b want %b %b", i, fwd_a, fwd_b,
                     m_fwd(pipe[0].rs), m_fwd(pipe[0].rt));
         end
         n_tests++;
         if ({br_fwd_a, br_fwd_b, id_wb_byp_rs, id_wb_byp_rt} !==
             {writes(pipe[1], id_rs) && !pipe[1].ld, writes(pipe[1], id_rt) && !pipe[1].ld,
              writes(pipe[2], id_rs), writes(pipe[2], id_rt)}) begin
            n_fail++;
            $display("FAIL rnd_byp[%0d]: got bfa=%b bfb=%b bys=%b byt=%b", i,
                     br_fwd_a, br_fwd_b, id_wb_byp_rs, id_wb_byp_rt);
         end
         n_tests++;
         if (stall_cnt !== 16'(m_stall_cnt) || flush_cnt !== 16'(m_flush_cnt)) begin
            n_fail++;
            $display("FAIL rnd_cnt[%0d]: got sc=%0d fc=%0d want %0d %0d", i, stall_cnt, flush_cnt,
                     m_stall_cnt, m_flush_cnt);
         end
         tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      nop();
      model_clear();
      test_reset();
      test_load_use();
      test_branch_alu();
      test_branch_load();
      test_mem_over_wb();
      test_zero_reg();
      test_flush();
      test_reset_mid_stall();
      test_saturation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
